// File: rtl/tff_counter_if.sv
// rtl/tff_counter_if.sv - control/data bundle for the tff_counter block
//
// Purpose: groups the per-cycle control inputs and registered outputs of
//          tff_counter so a driver and the counter share one connection.
// Signals:
//   en       enable for count or toggle operation
//   mode     0 = counter, 1 = toggle bank
//   up       count direction in counter mode (1 = up, 0 = down)
//   t        per-bit toggle mask (toggle mode only)
//   load     parallel load strobe
//   load_val parallel load value
//   q        registered state
//   tc       registered terminal-count pulse
// Modports: master drives controls and observes q/tc; slave is the counter.
interface tff_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             mode;
   logic             up;
   logic [WIDTH-1:0] t;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;

   modport master (
      output en, mode, up, t, load, load_val,
      input  q, tc
   );

   modport slave (
      input  en, mode, up, t, load, load_val,
      output q, tc
   );
endinterface

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - bounded up/down counter with a T flip-flop toggle bank
//
// Purpose: WIDTH-bit state register that either counts between 0 and
//          MAX_COUNT or toggles bits selected by a mask. A registered tc
//          pulse marks the cycle in which q shows a boundary event.
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-low reset (clears q and tc)
//   bus    tff_counter_if.slave: en, mode, up, t, load, load_val in;
//          q, tc out (both registered, one clock latency)
// Configuration:
//   TFF_COUNTER_SAT_EN undefined -> boundary events wrap (0 <-> MAX_COUNT)
//   TFF_COUNTER_SAT_EN defined   -> boundary events saturate
//   Toggle mode and load behave identically in both builds.
module tff_counter #(
   parameter int WIDTH     = 8,
   parameter int MAX_COUNT = 255
) (
   input  logic              clk,
   input  logic              reset,
   tff_counter_if.slave      bus
);

   localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO_Q = '0;

   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;

   // Priority: load > en > hold (reset is handled in the register stage).
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
      if (bus.load) begin
         q_d = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
      end else if (bus.en) begin
         if (bus.mode) begin
            // Toggle bank may leave q above MAX_COUNT; the next up count
            // treats that as a boundary event.
            q_d = q_q ^ bus.t;
         end else if (bus.up) begin
            if (q_q >= MAX_Q) begin
               tc_d = 1'b1;
`ifdef TFF_COUNTER_SAT_EN
               q_d  = MAX_Q;
`else
               q_d  = ZERO_Q;
`endif
            end else begin
               q_d = q_q + ONE_Q;
            end
         end else begin
            if (q_q == ZERO_Q) begin
               tc_d = 1'b1;
`ifdef TFF_COUNTER_SAT_EN
               q_d  = ZERO_Q;
`else
               q_d  = MAX_Q;
`endif
            end else begin
               q_d = q_q - ONE_Q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q  <= ZERO_Q;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign bus.q  = q_q;
   assign bus.tc = tc_q;

endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - self-checking bench for tff_counter (WIDTH=4, MAX_COUNT=9)
module tb_tff_counter;

   localparam int W   = 4;
   localparam int MAX = 9;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   tff_counter_if #(.WIDTH(W)) bus ();

   tff_counter #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference state: plain integers, rules applied arithmetically.
   int m_q  = 0;
   int m_tc = 0;

`ifdef TFF_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Apply one cycle of inputs, advance the model, compare q and tc to it.
   task automatic step(input bit r, input bit ld, input int lv, input bit e,
                       input bit m, input bit u, input int tt);
      int nq;
      reset        = r;
      bus.load     = ld;
      bus.load_val = W'(lv);
      bus.en       = e;
      bus.mode     = m;
      bus.up       = u;
      bus.t        = W'(tt);
      @(posedge clk);
      #1;
      if (!r) begin
         m_q = 0; m_tc = 0;
      end else if (ld) begin
         m_q = (lv > MAX) ? MAX : lv; m_tc = 0;
      end else if (e && m) begin
         m_q = m_q ^ tt; m_tc = 0;
      end else if (e && u) begin
         nq = m_q + 1;
         if (nq > MAX) begin m_tc = 1; m_q = SAT ? MAX : 0; end
         else begin m_tc = 0; m_q = nq; end
      end else if (e) begin
         nq = m_q - 1;
         if (nq < 0) begin m_tc = 1; m_q = SAT ? 0 : MAX; end
         else begin m_tc = 0; m_q = nq; end
      end else begin
         m_tc = 0;
      end
      check("model_q",  {28'd0, bus.q}, 32'(m_q));
      check("model_tc", {31'd0, bus.tc}, 32'(m_tc));
   endtask

   initial begin
      bus.en = 1'b0; bus.mode = 1'b0; bus.up = 1'b0;
      bus.t = '0; bus.load = 1'b0; bus.load_val = '0;
      #2;

      // Reset overrides load for two edges, then hold keeps q at 0.
      step(0, 1, 5, 0, 0, 0, 0);
      step(0, 1, 5, 0, 0, 0, 0);
      check("reset_q",  {28'd0, bus.q}, 32'd0);
      check("reset_tc", {31'd0, bus.tc}, 32'd0);
      step(1, 0, 0, 0, 0, 0, 0);
      check("hold_after_reset_q", {28'd0, bus.q}, 32'd0);

`ifndef TFF_COUNTER_SAT_EN
      // Up count 1..9 then wrap to 0 with a single tc pulse.
      for (int i = 1; i <= 10; i++) begin
         step(1, 0, 0, 1, 0, 1, 0);
         check("up_q",  {28'd0, bus.q}, 32'(i % 10));
         check("up_tc", {31'd0, bus.tc}, (i == 10) ? 32'd1 : 32'd0);
      end

      // Down wrap from 0.
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      check("down_wrap_q",  {28'd0, bus.q}, 32'd9);
      check("down_wrap_tc", {31'd0, bus.tc}, 32'd1);
      step(1, 0, 0, 1, 0, 0, 0);
      check("down_q",  {28'd0, bus.q}, 32'd8);
      check("down_tc", {31'd0, bus.tc}, 32'd0);

      // Clamped load, toggle above MAX_COUNT, then overflow on up count.
      step(1, 1, 12, 0, 0, 0, 0);
      check("load_clamp_q", {28'd0, bus.q}, 32'd9);
      step(1, 0, 0, 1, 1, 0, 6);
      check("toggle_q",  {28'd0, bus.q}, 32'd15);
      check("toggle_tc", {31'd0, bus.tc}, 32'd0);
      step(1, 0, 0, 1, 0, 1, 0);
      check("over_q",  {28'd0, bus.q}, 32'd0);
      check("over_tc", {31'd0, bus.tc}, 32'd1);
`else
      // Saturation at MAX_COUNT: every blocked step pulses tc.
      step(1, 1, 9, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 1, 0, 1, 0);
         check("sat_q",  {28'd0, bus.q}, 32'd9);
         check("sat_tc", {31'd0, bus.tc}, 32'd1);
      end
      step(1, 0, 0, 0, 0, 1, 0);
      check("sat_idle_tc", {31'd0, bus.tc}, 32'd0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      check("sat_down_q",  {28'd0, bus.q}, 32'd0);
      check("sat_down_tc", {31'd0, bus.tc}, 32'd1);
`endif

      // Load beats toggle; reset beats load.
      step(1, 1, 3, 1, 1, 0, 15);
      check("prio_load_q", {28'd0, bus.q}, 32'd3);
      step(0, 1, 3, 1, 1, 0, 15);
      check("prio_reset_q", {28'd0, bus.q}, 32'd0);

      // Randomized cycles against the reference model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 24) != 0),
              ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of q, t and load_val (WIDTH >= 2).
REQ-002 SHALL have parameter MAX_COUNT, default 255: upper count bound in count mode (MAX_COUNT >= 1 and MAX_COUNT <= 2**WIDTH-1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-low reset; state clears when low at a rising edge of clk.
REQ-005 SHALL have port en  input  1  enable for count or toggle operation.
REQ-006 SHALL have port mode  input  1  0 = counter, 1 = toggle bank.
REQ-007 SHALL have port up  input  1  count direction in counter mode: 1 = up, 0 = down.
REQ-008 SHALL have port t  input  WIDTH  per-bit toggle mask, used in toggle mode only.
REQ-009 SHALL have port load  input  1  parallel load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  parallel load value.
REQ-011 SHALL have port q  output  WIDTH  registered state.
REQ-012 SHALL have port tc  output  1  registered terminal-count pulse.

Function
REQ-013 SHALL apply, at each rising edge, the priority reset low > load > en > hold.
REQ-014 SHALL, on load, set q to the smaller of load_val and MAX_COUNT, regardless of mode and en, and set tc to 0.
REQ-015 SHALL, in toggle mode with en=1, set q to q XOR t, ignore MAX_COUNT, and set tc to 0.
REQ-016 SHALL, in counter mode with en=1 and up=1, set q to q+1 when q < MAX_COUNT.
REQ-017 SHALL, in counter mode with en=1 and up=0, set q to q-1 when q > 0.
REQ-018 SHALL treat q > MAX_COUNT (possible after toggle mode) on an up count as the boundary case.
REQ-019 SHALL, with en=0 and no load, hold q and set tc to 0.
REQ-020 SHALL drive tc high for exactly the one cycle in which q shows the result of a boundary event; tc SHALL be 0 otherwise.
REQ-021 SHALL have latency of one clock from input sampling to both q and tc; no combinational path from inputs to outputs.
REQ-022 SHALL sample mode, up and t fresh every cycle; a mode or direction change takes effect at the next edge with no idle cycle.

Reset
REQ-023 SHALL set q to 0 and tc to 0 at any rising edge where reset is low, overriding load and en.
REQ-024 SHALL apply reset mid-count or mid-toggle sequence identically, with no remnant state.
REQ-025 SHALL resume operation at the first rising edge after reset returns high.

Configuration
REQ-026 SHALL use macro TFF_COUNTER_SAT_EN to select boundary behaviour.
REQ-027 SHALL, without TFF_COUNTER_SAT_EN, wrap on a boundary event: an up count at q >= MAX_COUNT gives q=0, a down count at q=0 gives q=MAX_COUNT, and tc=1 in both cases.
REQ-028 SHALL, with TFF_COUNTER_SAT_EN, saturate on a boundary event: an up count at q >= MAX_COUNT gives q=MAX_COUNT, a down count at q=0 gives q=0, and tc=1 for every blocked step.
REQ-029 SHALL keep toggle mode and load behaviour identical in both builds.

Verification
REQ-030 SHALL pass the reset test (WIDTH=4, MAX_COUNT=9, wrap build): reset low for 2 edges with load=1, load_val=5 -> q=0, tc=0; reset high, hold -> q stays 0.
REQ-031 SHALL pass the up-count wrap test: mode=0, up=1, en=1 from q=0 for 10 edges -> q=1..9, then 0 with tc=1 only in that cycle.
REQ-032 SHALL pass the down-count wrap test: load_val=0 then down for 1 edge -> q=9, tc=1; next edge -> q=8, tc=0.
REQ-033 SHALL pass the toggle and overflow test: load_val=12 -> q=9 (clamped); mode=1, t=4'b0110 -> q=15; mode=0, up=1 -> q=0, tc=1.
REQ-034 SHALL pass the priority test: load=1, load_val=3, en=1, mode=1, t=4'hF -> q=3; reset low with load=1 -> q=0.
REQ-035 SHALL pass the saturate test (TFF_COUNTER_SAT_EN build): q=9, up, 3 edges -> q=9 with tc=1 each edge; en=0 -> tc=0.
